// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function used by the mux arbiter slice.
package mux_arb_pkg;

  typedef enum logic {EMPTY, FULL} slot_state_t;

  localparam int MAX_REQ = 64;
  localparam int PICK_W  = 6;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... wrapping at n; the first valid requester wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int n,
                                    input int ptr);
    pick_t res;
    int    k;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (!res.found && valid[k]) begin
          res.found = 1'b1;
          res.idx   = PICK_W'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_priority_picker
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_valid
);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = in_valid;
    pick                   = rr_pick(valid_ext, N_REQ, int'(rr_ptr));
    winner                 = SEL_W'(pick.idx);
    any_valid              = pick.found;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N-to-1 data mux, with a registered output slot.
// Optional packet lock enabled by defining MUX_RR_ARBITER_PKT_LOCK_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_last,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  input  logic                    out_ready
);

  slot_state_t       state;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  pick_winner;
  logic [SEL_W-1:0]  winner;
  logic [SEL_W-1:0]  next_ptr;
  logic              pick_any;
  logic              has_req;
  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] sel_data;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .in_valid  (in_valid),
    .rr_ptr    (rr_ptr),
    .winner    (pick_winner),
    .any_valid (pick_any)
  );

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_sel;

  // A locked packet owns the mux until its last beat, even if others are waiting.
  assign winner  = lock ? lock_sel : pick_winner;
  assign has_req = lock ? in_valid[lock_sel] : pick_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_sel <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      lock     <= !in_last[winner];
      lock_sel <= winner;
      out_last <= in_last[winner];
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign winner      = pick_winner;
  assign has_req     = pick_any;
  assign out_last    = 1'b0;
`endif

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;
  assign load      = rst_n && can_load && has_req;
  assign next_ptr  = (winner == SEL_W'(N_REQ - 1)) ? '0 : winner + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == SEL_W'(k)) begin
        sel_data = in_data[k*DATA_W +: DATA_W];
        in_ready[k] = load;
      end
    end
  end

  // Slot FSM: loading always refills, otherwise a consumed beat empties the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      state    <= FULL;
      out_data <= sel_data;
      out_sel  <= winner;
      rr_ptr   <= next_ptr;
    end else if (out_ready) begin
      state    <= EMPTY;
    end
  end

endmodule
